// File: rtl/uart_boot_loader_if.sv
// Signal bundle between the UART receiver, the boot loader and the memory write port.
// Handshakes:
//   rx_valid  : one-cycle pulse per byte; rx_data is meaningful only then. No back-pressure.
//   mem_valid : the loader holds mem_addr/mem_wdata stable while mem_valid=1; the command
//               completes on a rising edge where mem_valid and mem_ready are both 1.
// dbgState/dbgWidx expose the loader FSM state and word index for observation.
interface uart_boot_loader_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  busy;
  logic                  done;
  logic                  overrun;
  logic [1:0]            dbgState;
  logic [31:0]           dbgWidx;

  // Loader side: consumes bytes, issues memory writes.
  modport master (
    input  rx_data, rx_valid, mem_ready,
    output mem_valid, mem_addr, mem_wdata, busy, done, overrun, dbgState, dbgWidx
  );

  // Environment side: UART receiver plus memory.
  modport slave (
    output rx_data, rx_valid, mem_ready,
    input  mem_valid, mem_addr, mem_wdata, busy, done, overrun, dbgState, dbgWidx
  );
endinterface

// File: rtl/uart_boot_loader.sv
// Boot loader: parses a 4-byte little-endian word-count header, then packs the following
// bytes into little-endian 32-bit words written to consecutive addresses from BASE_ADDR.
// BASE_ADDR must be 4-byte aligned.
module uart_boot_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic               clk,
  input logic               rst,
  uart_boot_loader_if.master bus
);

  typedef enum logic [1:0] {
    HEADER = 2'd0,
    DATA   = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                stateQ, stateD;
  logic [1:0]            byteCnt;
  logic [23:0]           asmWord;    // bytes 0..2 of the word being assembled
  logic [31:0]           lenReg;
  logic [31:0]           wordIdx;
  logic [31:0]           wordIdxInc;
  logic [31:0]           fullWord;
  logic                  memValidQ;
  logic [ADDR_WIDTH-1:0] memAddrQ;
  logic [ADDR_WIDTH-1:0] addrNext;
  logic [31:0]           memWdataQ;
  logic                  doneQ;
  logic                  overrunQ;
  logic                  byteIn;
  logic                  wordIn;
  logic                  handshake;
  logic                  loadCmd;
  logic                  dropWord;

  // Bytes are ignored once the image is complete.
  assign byteIn     = bus.rx_valid && (stateQ != DONE);
  assign wordIn     = byteIn && (byteCnt == 2'd3);
  // The 4th byte is used straight from the input so the word is usable on its arrival edge.
  assign fullWord   = {bus.rx_data, asmWord};
  assign handshake  = memValidQ && bus.mem_ready;
  assign wordIdxInc = wordIdx + 32'd1;
  assign addrNext   = BASE_ADDR + ADDR_WIDTH'({wordIdx, 2'b00});

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateQ <= HEADER;
    else     stateQ <= stateD;
  end

  // Next state plus command-load / overrun-drop decisions for a completed word.
  always_comb begin
    stateD   = stateQ;
    loadCmd  = 1'b0;
    dropWord = 1'b0;
    case (stateQ)
      HEADER: begin
        if (wordIn) stateD = (fullWord == 32'd0) ? DONE : DATA;
      end
      DATA: begin
        if (wordIn) begin
          // A command completing this edge frees the slot for the new word.
          if (!memValidQ || handshake) loadCmd  = 1'b1;
          else                         dropWord = 1'b1;
          if (wordIdxInc == lenReg) stateD = DONE;
        end
      end
      DONE:    stateD = DONE;
      default: stateD = HEADER;
    endcase
  end

  // Byte assembly, header/word bookkeeping, memory command and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byteCnt   <= 2'd0;
      asmWord   <= 24'd0;
      lenReg    <= 32'd0;
      wordIdx   <= 32'd0;
      memValidQ <= 1'b0;
      memAddrQ  <= '0;
      memWdataQ <= 32'd0;
      doneQ     <= 1'b0;
      overrunQ  <= 1'b0;
    end else begin
      if (byteIn) begin
        case (byteCnt)
          2'd0:    asmWord[7:0]   <= bus.rx_data;
          2'd1:    asmWord[15:8]  <= bus.rx_data;
          2'd2:    asmWord[23:16] <= bus.rx_data;
          default: ;
        endcase
        byteCnt <= byteCnt + 2'd1;
      end
      if (stateQ == HEADER && wordIn) begin
        lenReg  <= fullWord;
        wordIdx <= 32'd0;
      end
      // Discarded words still consume an address slot.
      if (stateQ == DATA && wordIn) wordIdx <= wordIdxInc;
      if (loadCmd) begin
        memValidQ <= 1'b1;
        memAddrQ  <= addrNext;
        memWdataQ <= fullWord;
      end else if (handshake) begin
        memValidQ <= 1'b0;
      end
      if (dropWord) overrunQ <= 1'b1;
      if (stateQ == DONE && !memValidQ) doneQ <= 1'b1;
    end
  end

  assign bus.mem_valid = memValidQ;
  assign bus.mem_addr  = memAddrQ;
  assign bus.mem_wdata = memWdataQ;
  assign bus.done      = doneQ;
  assign bus.overrun   = overrunQ;
  assign bus.busy      = ((stateQ != HEADER) || (byteCnt != 2'd0)) && !doneQ;
  assign bus.dbgState  = stateQ;
  assign bus.dbgWidx   = wordIdx;

endmodule
